// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver_if
// Brief    : Control/data bundle between a display client and seg_scan_driver.
// Revision : 1.0
// ============================================================================
interface seg_scan_driver_if;
    logic        en;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit;
    logic        tick;

    modport master (
        output en, load, din, dp_in,
        input  an, seg, dp, digit, tick
    );

    modport slave (
        input  en, load, din, dp_in,
        output an, seg, dp, digit, tick
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Four-digit multiplexed seven-segment driver, active-low pins.
// Revision : 1.0
// ============================================================================
module seg_scan_driver #(
    parameter int DIV      = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  wire logic        c,
    input  wire logic        rst,
    seg_scan_driver_if.slave bus
);
    localparam int              c_PW   = $clog2(DIV);
    localparam logic [c_PW-1:0] c_TERM = c_PW'(DIV - 1);

    logic [c_PW-1:0] r_presc;
    logic [1:0]      r_digit;
    logic            r_tick;
    logic [15:0]     r_data;
    logic [3:0]      r_dp;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dpo;

    logic            w_wrap;
    logic [3:0]      w_nib;
    logic [6:0]      w_seg;
    logic [3:0]      w_an;
    logic            w_blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign w_wrap = bus.en && (r_presc == c_TERM);
    assign w_nib  = r_data[{r_digit, 2'b00} +: 4];
    assign w_seg  = hex7(w_nib);
    assign w_an   = ~(4'b0001 << r_digit);

    // A digit is blank when it and every more-significant nibble are zero;
    // the rightmost digit is always shown so a zero value still reads "0".
    generate
        if (BLANK_LZ) begin : g_blank_lz
            always_comb begin
                w_blank = 1'b0;
                case (r_digit)
                    2'd3:    w_blank = (r_data[15:12] == 4'h0);
                    2'd2:    w_blank = (r_data[15:8]  == 8'h00);
                    2'd1:    w_blank = (r_data[15:4]  == 12'h000);
                    default: w_blank = 1'b0;
                endcase
            end
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

    always_ff @(posedge c) begin
        if (!rst) begin
            r_presc <= '0;
            r_digit <= 2'd0;
            r_tick  <= 1'b0;
            r_data  <= 16'h0000;
            r_dp    <= 4'h0;
            r_an    <= 4'b1111;
            r_seg   <= 7'b1111111;
            r_dpo   <= 1'b1;
        end else begin
            if (bus.en) begin
                r_presc <= w_wrap ? '0 : r_presc + c_PW'(1);
                if (w_wrap) begin
                    r_digit <= r_digit + 2'd1;
                end
            end
            r_tick <= w_wrap;
            if (bus.load) begin
                r_data <= bus.din;
                r_dp   <= bus.dp_in;
            end
            // Pins reflect the pre-edge digit and shadow, one cycle behind.
            if (bus.en && !w_blank) begin
                r_an  <= w_an;
                r_seg <= w_seg;
                r_dpo <= ~r_dp[r_digit];
            end else begin
                r_an  <= 4'b1111;
                r_seg <= 7'b1111111;
                r_dpo <= 1'b1;
            end
        end
    end

    assign bus.an    = r_an;
    assign bus.seg   = r_seg;
    assign bus.dp    = r_dpo;
    assign bus.digit = r_digit;
    assign bus.tick  = r_tick;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed bench for seg_scan_driver, both blanking variants.
// Revision : 1.0
// ============================================================================
module tb_seg_scan_driver;
    localparam int DIV = 4;

    logic        c = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;

    int total  = 0;
    int passed = 0;

    seg_scan_driver_if bus0();
    seg_scan_driver_if bus1();

    assign bus0.en = en;  assign bus0.load = load;  assign bus0.din = din;  assign bus0.dp_in = dp_in;
    assign bus1.en = en;  assign bus1.load = load;  assign bus1.din = din;  assign bus1.dp_in = dp_in;

    seg_scan_driver #(.DIV(DIV), .BLANK_LZ(1'b0)) dut0 (.c(c), .rst(rst), .bus(bus0));
    seg_scan_driver #(.DIV(DIV), .BLANK_LZ(1'b1)) dut1 (.c(c), .rst(rst), .bus(bus1));

    always #5 c = ~c;

    // Reference decode table, most-significant bit is segment g.
    logic [6:0] hex_tab [16];
    initial begin
        hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001; hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
        hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010; hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
        hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000; hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
        hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001; hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
    end

    // Model: everything follows from the number of enabled cycles since reset.
    int          m_n     = 0;
    logic [15:0] m_sh    = '0;
    logic [3:0]  m_shdp  = '0;
    logic        m_tick  = 1'b0;
    logic [11:0] m_pins0 = '1;
    logic [11:0] m_pins1 = '1;
    logic        m_valid = 1'b0;

    function automatic int dig_of(input int n);
        return (n / DIV) % 4;
    endfunction

    // Returns {an, seg, dp} for digit k.
    function automatic logic [11:0] render(input int k, input logic [15:0] sh,
                                           input logic [3:0] shdp, input bit blz);
        logic [15:0] upper;
        logic [3:0]  an;
        upper = sh >> (4 * k);
        if (blz && k > 0 && upper == 16'h0000) return 12'hFFF;
        an = ~(4'b0001 << k);
        return {an, hex_tab[upper[3:0]], ~shdp[k]};
    endfunction

    always @(posedge c) begin
        if (!rst) begin
            m_n <= 0; m_sh <= '0; m_shdp <= '0; m_tick <= 1'b0;
            m_pins0 <= '1; m_pins1 <= '1;
        end else begin
            m_pins0 <= en ? render(dig_of(m_n), m_sh, m_shdp, 1'b0) : 12'hFFF;
            m_pins1 <= en ? render(dig_of(m_n), m_sh, m_shdp, 1'b1) : 12'hFFF;
            if (en) begin
                m_n    <= m_n + 1;
                m_tick <= ((m_n + 1) % DIV) == 0;
            end else begin
                m_tick <= 1'b0;
            end
            if (load) begin
                m_sh   <= din;
                m_shdp <= dp_in;
            end
        end
        m_valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    always @(negedge c) begin
        if (m_valid) begin
            chk("m0.digit", 16'(bus0.digit), 16'(dig_of(m_n)));
            chk("m0.tick",  16'(bus0.tick),  16'(m_tick));
            chk("m0.pins",  16'({bus0.an, bus0.seg, bus0.dp}), 16'(m_pins0));
            chk("m1.digit", 16'(bus1.digit), 16'(dig_of(m_n)));
            chk("m1.tick",  16'(bus1.tick),  16'(m_tick));
            chk("m1.pins",  16'({bus1.an, bus1.seg, bus1.dp}), 16'(m_pins1));
        end
    end

    // Returns at the negedge where the scan index has just become k.
    task automatic wait_digit(input logic [1:0] k);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge c);
            if (bus0.digit == k && bus0.tick) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) $display("FAIL wait_digit: digit %0d never arrived (got %0d)", k, bus0.digit);
        else passed++;
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        load = 1'b1; din = d; dp_in = p;
        @(negedge c);
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] an_e  [4];
        logic [6:0] seg_e [4];
        an_e[0]  = 4'b1110;    an_e[1]  = 4'b1101;    an_e[2]  = 4'b1011;    an_e[3]  = 4'b0111;
        seg_e[0] = 7'b0011001; seg_e[1] = 7'b0110000; seg_e[2] = 7'b0100100; seg_e[3] = 7'b1111001;

        rst = 1'b0; en = 1'b0; load = 1'b0; din = '0; dp_in = '0;
        repeat (2) @(negedge c);
        chk("rst.an",    16'(bus0.an),    16'(4'b1111));
        chk("rst.seg",   16'(bus0.seg),   16'(7'b1111111));
        chk("rst.dp",    16'(bus0.dp),    16'(1'b1));
        chk("rst.digit", 16'(bus0.digit), 16'(2'd0));
        chk("rst.tick",  16'(bus0.tick),  16'(1'b0));

        rst = 1'b1; en = 1'b1;
        load_word(16'h1234, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            wait_digit(2'(k % 4));
            @(negedge c);
            chk("scan.an",  16'(bus0.an),  16'(an_e[k % 4]));
            chk("scan.seg", 16'(bus0.seg), 16'(seg_e[k % 4]));
        end

        load_word(16'h0050, 4'h0);
        wait_digit(2'd3); @(negedge c);
        chk("lz.d3.an", 16'(bus1.an), 16'(4'b1111));
        wait_digit(2'd0); @(negedge c);
        chk("lz.d0.an",  16'(bus1.an),  16'(4'b1110));
        chk("lz.d0.seg", 16'(bus1.seg), 16'(7'b1000000));
        wait_digit(2'd1); @(negedge c);
        chk("lz.d1.an",  16'(bus1.an),  16'(4'b1101));
        chk("lz.d1.seg", 16'(bus1.seg), 16'(7'b0010010));
        wait_digit(2'd2); @(negedge c);
        chk("lz.d2.an", 16'(bus1.an), 16'(4'b1111));

        load_word(16'h0000, 4'h0);
        wait_digit(2'd0); @(negedge c);
        chk("zero.d0.seg", 16'(bus1.seg), 16'(7'b1000000));
        wait_digit(2'd1); @(negedge c);
        chk("zero.d1.an", 16'(bus1.an), 16'(4'b1111));

        load_word(16'h8888, 4'b0100);
        wait_digit(2'd2); @(negedge c);
        chk("dp.d2.an",  16'(bus0.an),  16'(4'b1011));
        chk("dp.d2.dp",  16'(bus0.dp),  16'(1'b0));
        chk("dp.d2.seg", 16'(bus0.seg), 16'(7'b0000000));
        wait_digit(2'd3); @(negedge c);
        chk("dp.d3.dp", 16'(bus0.dp), 16'(1'b1));

        // Freeze with prescaler at 2 inside the digit-1 slot.
        wait_digit(2'd1);
        repeat (2) @(negedge c);
        en = 1'b0;
        @(negedge c);
        chk("hold.an",    16'(bus0.an),    16'(4'b1111));
        chk("hold.digit", 16'(bus0.digit), 16'(2'd1));
        repeat (9) @(negedge c);
        en = 1'b1;
        @(negedge c);
        chk("resume1.digit", 16'(bus0.digit), 16'(2'd1));
        @(negedge c);
        chk("resume2.digit", 16'(bus0.digit), 16'(2'd2));
        chk("resume2.tick",  16'(bus0.tick),  16'(1'b1));

        // Load lands on the same edge as the 3->0 wrap.
        load_word(16'hABCD, 4'h0);
        wait_digit(2'd3);
        repeat (3) @(negedge c);
        load_word(16'h000F, 4'h0);
        chk("wrapld.digit", 16'(bus0.digit), 16'(2'd0));
        @(negedge c);
        chk("wrapld.seg0", 16'(bus0.seg), 16'(7'b0001110));
        chk("wrapld.seg1", 16'(bus1.seg), 16'(7'b0001110));

        wait_digit(2'd2);
        @(negedge c);
        rst = 1'b0;
        @(negedge c);
        chk("mrst.digit", 16'(bus0.digit), 16'(2'd0));
        chk("mrst.an",    16'(bus0.an),    16'(4'b1111));
        chk("mrst.seg",   16'(bus0.seg),   16'(7'b1111111));
        rst = 1'b1;
        @(negedge c);
        chk("post.seg0", 16'(bus0.seg), 16'(7'b1000000));
        chk("post.seg1", 16'(bus1.seg), 16'(7'b1000000));
        chk("post.an1",  16'(bus1.an),  16'(4'b1110));
        repeat (20) @(negedge c);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
